// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - key code constants (KEY_NONE doubles as the idle code on num)
//   - debounce FSM state enum
//   - pos_to_code(): matrix position (row*4 + col) to key code
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  localparam logic [3:0] KEY_NONE = 4'd11;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } db_state_e;

  // Layout, rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// sync2: W-bit two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, loads RST_VAL into both stages
//   d_i    - asynchronous input
//   q_o    - synchronized output (2-cycle latency)
module sync2 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with whole-sweep debounce.
// Ports:
//   FPGA_CLK1_50 - system clock
//   reset        - synchronous active-high reset
//   kp_row[3:0]  - keypad rows, asynchronous, active-low (pulled up)
//   kp_col[3:0]  - column drive, active-low one-hot
//   num[3:0]     - debounced key code, KEY_NONE (11) while no key held
//   PB_state     - high while a debounced key is held
//   key_valid    - one-cycle pulse on each press commit
//
// Debounce FSM:
//   state        | meaning
//   RELEASED     | no key committed, waiting for a single-key sweep
//   PRESS_PEND   | key_q seen for cnt_q consecutive sweeps, not yet committed
//   PRESSED      | key_q committed, num/PB_state asserted
//   RELEASE_PEND | key_q absent for cnt_q consecutive sweeps, still committed
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_SWEEPS = 10
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  output logic [3:0] num,
  output logic       PB_state,
  output logic       key_valid
);

  localparam int              SW        = $clog2(SCAN_DIV);
  localparam int              CW        = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   CNT_TERM  = CW'(DEBOUNCE_SWEEPS);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam bit              ONE_SWEEP = (DEBOUNCE_SWEEPS == 1);

  logic [3:0]    row_s;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    kp_col_q, kp_col_d;
  logic [15:0]   image_q, image_d, image_now;
  logic          slot_last, sweep_end;

  logic [4:0]    low_cnt;
  logic [3:0]    low_pos;
  logic          res_valid;
  logic [3:0]    res_code;

  db_state_e     state_q, state_d;
  logic [3:0]    key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    num_q, num_d;
  logic          pb_q, pb_d;
  logic          kv_q, kv_d;
  logic          match;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_row_sync (
    .clk_i (FPGA_CLK1_50),
    .rst_i (reset),
    .d_i   (kp_row),
    .q_o   (row_s)
  );

  // Scan counters and sweep image. image bit index = row*4 + col.
  always_comb begin
    slot_last = (slot_q == SLOT_LAST);
    sweep_end = slot_last && (col_q == 2'd3);
    slot_d    = slot_last ? '0 : slot_q + 1'b1;
    col_d     = slot_last ? col_q + 2'd1 : col_q;
    kp_col_d  = ~(4'b0001 << col_d);

    // Current column's rows merged in so the sweep-end evaluation sees
    // column 3's sample in the same cycle it is taken.
    image_now = image_q;
    for (int r = 0; r < 4; r++) begin
      image_now[4'(r * 4) + {2'b00, col_q}] = row_s[r];
    end
    image_d = slot_last ? image_now : image_q;
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      slot_q   <= '0;
      col_q    <= 2'd0;
      kp_col_q <= 4'b1110;
      image_q  <= '1;
    end else begin
      slot_q   <= slot_d;
      col_q    <= col_d;
      kp_col_q <= kp_col_d;
      image_q  <= image_d;
    end
  end

  // Sweep result: exactly one low bit is a key; none or several is NONE.
  always_comb begin
    low_cnt = '0;
    low_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (!image_now[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_pos = 4'(i);
      end
    end
    res_valid = (low_cnt == 5'd1);
    res_code  = pos_to_code(low_pos);
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) state_q <= RELEASED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    pb_d    = pb_q;
    kv_d    = 1'b0;
    cnt_inc = (cnt_q == CNT_TERM) ? cnt_q : cnt_q + 1'b1;
    match   = res_valid && (res_code == key_q);

    if (sweep_end) begin
      case (state_q)
        RELEASED: begin
          if (res_valid) begin
            key_d = res_code;
            if (ONE_SWEEP) begin
              state_d = PRESSED;
              cnt_d   = '0;
              num_d   = res_code;
              pb_d    = 1'b1;
              kv_d    = 1'b1;
            end else begin
              state_d = PRESS_PEND;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PRESS_PEND: begin
          if (match) begin
            if (cnt_inc == CNT_TERM) begin
              state_d = PRESSED;
              cnt_d   = '0;
              num_d   = key_q;
              pb_d    = 1'b1;
              kv_d    = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (!res_valid) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            // A different single key restarts the press count.
            key_d = res_code;
            cnt_d = CNT_ONE;
          end
        end
        PRESSED: begin
          if (!match) begin
            if (ONE_SWEEP) begin
              state_d = RELEASED;
              cnt_d   = '0;
              num_d   = KEY_NONE;
              pb_d    = 1'b0;
            end else begin
              state_d = RELEASE_PEND;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RELEASE_PEND: begin
          if (match) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_TERM) begin
            state_d = RELEASED;
            cnt_d   = '0;
            num_d   = KEY_NONE;
            pb_d    = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          num_d   = KEY_NONE;
          pb_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      key_q <= KEY_NONE;
      cnt_q <= '0;
      num_q <= KEY_NONE;
      pb_q  <= 1'b0;
      kv_q  <= 1'b0;
    end else begin
      key_q <= key_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      pb_q  <= pb_d;
      kv_q  <= kv_d;
    end
  end

  assign kp_col    = kp_col_q;
  assign num       = num_q;
  assign PB_state  = pb_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  logic       clk;
  logic       reset;
  logic [3:0] kp_row;
  logic [3:0] kp_col;
  logic [3:0] num;
  logic       PB_state;
  logic       key_valid;

  logic [15:0] pressed;
  int checks;
  int errors;
  logic       prev_pb;
  logic [3:0] prev_num;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SWEEPS(3)) dut (
    .FPGA_CLK1_50 (clk),
    .reset        (reset),
    .kp_row       (kp_row),
    .kp_col       (kp_col),
    .num          (num),
    .PB_state     (PB_state),
    .key_valid    (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key shorts its row to its driven column.
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4 + c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    logic        pb;
    logic [3:0]  nm;
    logic        kv;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] km(input int idx);
    logic [15:0] m;
    m = 16'd1;
    return m << idx;
  endfunction

  function automatic void add(input logic [15:0] keys, input logic pb,
                              input logic [3:0] nm, input logic kv, input string name);
    vec_t v;
    v.keys = keys; v.pb = pb; v.nm = nm; v.kv = kv; v.name = name;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One full 16-cycle sweep with a fixed key pattern, starting at sweep cycle 0.
  task automatic run_sweep(input logic [15:0] keys, input logic exp_pb,
                           input logic [3:0] exp_num, input logic exp_kv, input string name);
    logic bad_col, bad_hold, extra_kv;
    logic [3:0] one, exp_col;
    int col;
    bad_col = 0; bad_hold = 0; extra_kv = 0;
    one = 4'b0001;
    pressed = keys;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      col = ((i + 1) % 16) / 4;
      exp_col = ~(one << col);
      if (kp_col !== exp_col) bad_col = 1;
      if (i < 15) begin
        if (PB_state !== prev_pb || num !== prev_num) bad_hold = 1;
        if (key_valid !== 1'b0) extra_kv = 1;
      end
    end
    chk({name, " kp_col"}, {31'd0, bad_col}, 32'd0);
    chk({name, " hold"}, {31'd0, bad_hold}, 32'd0);
    chk({name, " kv_width"}, {31'd0, extra_kv}, 32'd0);
    chk({name, " PB_state"}, {31'd0, PB_state}, {31'd0, exp_pb});
    chk({name, " num"}, {28'd0, num}, {28'd0, exp_num});
    chk({name, " key_valid"}, {31'd0, key_valid}, {31'd0, exp_kv});
    prev_pb  = exp_pb;
    prev_num = exp_num;
  endtask

  task automatic reset_check(input string name);
    reset = 1'b1;
    @(posedge clk); #1;
    chk({name, " kp_col"}, {28'd0, kp_col}, 32'he);
    chk({name, " num"}, {28'd0, num}, 32'd11);
    chk({name, " PB_state"}, {31'd0, PB_state}, 32'd0);
    chk({name, " key_valid"}, {31'd0, key_valid}, 32'd0);
    reset = 1'b0;
    prev_pb  = 1'b0;
    prev_num = 4'd11;
  endtask

  initial begin
    logic [15:0] none, k5, kd, k1, k9, khash, k2, k3, kb, k0, k7;
    checks = 0;
    errors = 0;
    pressed = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset0");

    none = '0;
    k5 = km(5);  kd = km(15); k1 = km(0);  k9 = km(10); khash = km(14);
    k2 = km(1);  k3 = km(2);  kb = km(7);  k0 = km(13); k7 = km(8);

    add(none, 0, 11, 0, "idle1");
    add(none, 0, 11, 0, "idle2");
    add(k5, 0, 11, 0, "k5_s1");
    add(k5, 0, 11, 0, "k5_s2");
    add(k5, 1, 5, 1, "k5_s3");
    add(k5, 1, 5, 0, "k5_s4");
    add(k5, 1, 5, 0, "k5_s5");
    add(none, 1, 5, 0, "k5_r1");
    add(none, 1, 5, 0, "k5_r2");
    add(none, 0, 11, 0, "k5_r3");
    add(kd, 0, 11, 0, "d_b1");
    add(kd, 0, 11, 0, "d_b2");
    add(none, 0, 11, 0, "d_gap");
    add(kd, 0, 11, 0, "d_s1");
    add(kd, 0, 11, 0, "d_s2");
    add(kd, 1, 13, 1, "d_s3");
    add(none, 1, 13, 0, "d_r1");
    add(none, 1, 13, 0, "d_r2");
    add(none, 0, 11, 0, "d_r3");
    for (int i = 0; i < 6; i++) add(k1 | k9, 0, 11, 0, "ghost");
    add(none, 0, 11, 0, "ghost_end");
    add(khash, 0, 11, 0, "h_s1");
    add(khash, 0, 11, 0, "h_s2");
    add(khash, 1, 15, 1, "h_s3");
    add(none, 1, 15, 0, "h_gap");
    add(khash, 1, 15, 0, "h_back");
    add(khash, 1, 15, 0, "h_hold");
    add(none, 1, 15, 0, "h_r1");
    add(none, 1, 15, 0, "h_r2");
    add(none, 0, 11, 0, "h_r3");
    add(k2, 0, 11, 0, "k2_s1");
    add(k2, 0, 11, 0, "k2_s2");
    add(k3, 0, 11, 0, "k3_s1");
    add(k3, 0, 11, 0, "k3_s2");
    add(k3, 1, 3, 1, "k3_s3");
    add(none, 1, 3, 0, "k3_r1");
    add(none, 1, 3, 0, "k3_r2");
    add(none, 0, 11, 0, "k3_r3");
    add(kb, 0, 11, 0, "kb_s1");
    add(kb, 0, 11, 0, "kb_s2");
    add(kb, 1, 11, 1, "kb_s3");
    add(none, 1, 11, 0, "kb_r1");
    add(none, 1, 11, 0, "kb_r2");
    add(none, 0, 11, 0, "kb_r3");
    add(k0, 0, 11, 0, "k0_s1");
    add(k0, 0, 11, 0, "k0_s2");
    add(k0, 1, 0, 1, "k0_s3");
    add(none, 1, 0, 0, "k0_r1");
    add(none, 1, 0, 0, "k0_r2");
    add(none, 0, 11, 0, "k0_r3");

    foreach (vq[i]) run_sweep(vq[i].keys, vq[i].pb, vq[i].nm, vq[i].kv, vq[i].name);

    // Reset during PRESS_PEND: the full debounce is needed afterwards.
    run_sweep(k7, 0, 11, 0, "k7_pp1");
    run_sweep(k7, 0, 11, 0, "k7_pp2");
    pressed = k7;
    repeat (5) @(posedge clk);
    #1;
    reset_check("rst_pp");
    run_sweep(k7, 0, 11, 0, "k7_a1");
    run_sweep(k7, 0, 11, 0, "k7_a2");
    run_sweep(k7, 1, 7, 1, "k7_a3");

    // Reset during PRESSED.
    run_sweep(k7, 1, 7, 0, "k7_hold");
    repeat (9) @(posedge clk);
    #1;
    reset_check("rst_pr");
    run_sweep(k7, 0, 11, 0, "k7_b1");
    run_sweep(k7, 0, 11, 0, "k7_b2");
    run_sweep(k7, 1, 7, 1, "k7_b3");
    run_sweep(none, 1, 7, 0, "k7_r1");
    run_sweep(none, 1, 7, 0, "k7_r2");
    run_sweep(none, 0, 11, 0, "k7_r3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix scanner for the 4x4 room-terminal keypad. Drives columns one at a time, samples rows, debounces whole-matrix sweeps, and presents a single debounced key code `num` with level `PB_state`. Sits directly upstream of the key-to-ASCII/UART start stage, which consumes `num` and `PB_state` unchanged.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per column slot (1 ms at 50 MHz); must be ≥ 4.
- `DEBOUNCE_SWEEPS`, 10: consecutive identical sweep results required to commit a press or release; must be ≥ 1.

Ports:
- `FPGA_CLK1_50`  in  1  system clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `kp_row`  in  4  keypad rows; asynchronous, pulled up, active-low.
- `kp_col`  out  4  column drive; active-low one-hot.
- `num`  out  4  debounced key code.
- `PB_state`  out  1  high while a debounced key is held.
- `key_valid`  out  1  one-cycle pulse on each press commit.

## Operation
- Layout, rows top to bottom, columns 0–3: `1 2 3 A` / `4 5 6 B` / `7 8 9 C` / `* 0 # D`.
- Codes: digits map to their value. `A`=10, `B`=11, `C`=12, `D`=13, `*`=14, `#`=15.
- Idle code: `num`=11 whenever `PB_state`=0. Downstream treats 11 as "no key", and `PB_state` disambiguates the `B` key.
- `kp_row` passes through a 2-FF synchronizer before any use.
- Column counter steps 0→1→2→3→0. `kp_col` = ~(1<<col).
- A slot counter runs 0..`SCAN_DIV`-1 within each column. Synchronized rows are sampled on the last cycle of each slot, into a 16-bit sweep image.
- At the end of column 3's slot, the sweep result is formed:
  - exactly one bit low in the image: the key code;
  - zero bits low, or two or more bits low: NONE. Multiple presses are rejected as ghosting.
- Debounce FSM, evaluated once per sweep end. A match counter saturates at `DEBOUNCE_SWEEPS`.
  - RELEASED: a single key K starts a new count at 1, then goes to PRESS_PEND(K).
  - PRESS_PEND(K):
    - result K increments the count;
    - result NONE returns to RELEASED;
    - a different key K2 restarts PRESS_PEND(K2) with count 1;
    - when the count reaches `DEBOUNCE_SWEEPS`, go to PRESSED(K): `num`←K, `PB_state`←1, `key_valid` pulses.
  - PRESSED(K): any result other than K starts a count at 1 and goes to RELEASE_PEND(K). Result K stays.
  - RELEASE_PEND(K):
    - result K returns to PRESSED(K) with no new `key_valid`;
    - any other result increments the count;
    - when the count reaches `DEBOUNCE_SWEEPS`, go to RELEASED: `PB_state`←0, `num`←11.
- Rollover is not supported. A new key always needs a full release, then a full press debounce.

## Timing
- Reset values: `kp_col`=4'b1110, column 0, slot counter 0, sweep image all-ones, FSM RELEASED, count 0, `num`=11, `PB_state`=0, `key_valid`=0.
- Reset asserted mid-sweep or mid-debounce returns to the above on the next edge. No partial state survives.
- Sweep period: 4·`SCAN_DIV` cycles. The first sweep after reset ends at cycle 4·`SCAN_DIV`-1.
- Outputs are registered. They update on the cycle after the sweep-end evaluation.
- Press latency: `PB_state` rises one cycle after the end of the `DEBOUNCE_SWEEPS`-th consecutive sweep containing the key.
- Release latency follows the same rule for consecutive non-K sweeps.
- `key_valid` is high for exactly one cycle, coincident with the first cycle `PB_state`=1.
- `num` is stable for the whole time `PB_state`=1.
- Row settle: the column drive changes at the slot start. Sampling at the slot end allows `SCAN_DIV`-1 cycles for settling plus the 2-cycle synchronizer.

## Structure
- Package `keypad_pkg`:
  - key code constants `KEY_A`..`KEY_HASH`, `KEY_NONE`=4'd11;
  - FSM state enum {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND};
  - the 16-entry position-to-code function.
- One sub-module, `sync2`: a parameterized-width 2-FF synchronizer, instantiated at 4 bits for `kp_row`.
- Scan counters, sweep image, result encoder and debounce FSM all live in `keypad_scan`.

## Test plan
All cases use `SCAN_DIV`=4 and `DEBOUNCE_SWEEPS`=3.
- Reset, no key: `kp_col` cycles 1110→1101→1011→0111 every 4 cycles; `num`=11, `PB_state`=0 throughout.
- Hold key `5` (row 1 low when col 1 driven) for 5 sweeps:
  - `PB_state` rises 1 cycle after the 3rd sweep end, with `num`=5 and a single-cycle `key_valid`;
  - release for 3 sweeps: `PB_state`=0, `num`=11.
- Bounce on `D`: key present for 2 sweeps, absent for 1, present for 3 → exactly one `key_valid`, `num`=13, timed from the last run of 3.
- Two keys (`1` and `9`) held together for 6 sweeps → `PB_state` stays 0, no `key_valid`.
- `#` held until PRESSED, then one NONE sweep, then `#` again → `PB_state` stays 1, `num`=15, no second `key_valid`.
- `reset` asserted during PRESS_PEND and during PRESSED → next cycle `num`=11, `PB_state`=0, `kp_col`=1110; the full 3-sweep debounce is required afterwards.
